// File: rtl/grouped_max_broadcast_pkg.sv
// Shared types for the softmax-approximation tree: one delay-line slot and the grouping FSM states.
package softmax_tree_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {DATA_W-1{1'b0}}};

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] loc_max;
        logic [DATA_W-1:0] grp_max;
        logic              last;
        logic              partial;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } grp_state_e;

endpackage

// File: rtl/grouped_max_broadcast_acc.sv
// Signed running maximum of an open group. front is the max including the current beat,
// acc is the registered max of the beats already accepted.
module grp_max_acc
    import softmax_tree_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_first,
    input  logic [DATA_W-1:0] i_val,
    output logic [DATA_W-1:0] o_front,
    output logic [DATA_W-1:0] o_acc
);

    logic [DATA_W-1:0] acc_q;

    // A first beat ignores whatever acc holds; ties keep acc.
    always_comb begin
        o_front = acc_q;
        if (i_first || ($signed(i_val) > $signed(acc_q))) begin
            o_front = i_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= MIN_VAL;
        end else if (i_en) begin
            if (i_clear) begin
                acc_q <= MIN_VAL;
            end else if (i_load) begin
                acc_q <= o_front;
            end
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/grouped_max_broadcast.sv
// Group max-forwarding stage: forms the signed max over each group of beats and writes it back
// onto every member while the members are still inside a MAX_GRP-deep delay line.
module grouped_max_broadcast
    import softmax_tree_pkg::*;
#(
    parameter int DATA_W  = softmax_tree_pkg::DATA_W,  // slot fields follow the package width
    parameter int MAX_GRP = 12,
    parameter int BYP_W   = 1024,
    parameter int CNT_W   = $clog2(MAX_GRP + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_loc_max,
    input  logic              i_last,
    input  logic [CNT_W-1:0]  i_grp_len,
    input  logic [BYP_W-1:0]  i_byp,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_grp_max,
    output logic [DATA_W-1:0] o_loc_max,
    output logic              o_last,
    output logic              o_partial,
    output logic [BYP_W-1:0]  o_byp
);

    grp_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_q;
    beat_t             slot_q [MAX_GRP];
    beat_t             slot_d [MAX_GRP];
    logic [BYP_W-1:0]  byp_q  [MAX_GRP];

    logic              first;
    logic              close;
    logic              abort;
    logic              load;
    logic [CNT_W-1:0]  eff_len;
    logic [DATA_W-1:0] front;
    logic [DATA_W-1:0] acc;
    beat_t             out_beat;

    grp_max_acc u_acc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_load  (load),
        .i_clear (close || abort),
        .i_first (first),
        .i_val   (i_loc_max),
        .o_front (front),
        .o_acc   (acc)
    );

    always_comb begin
        eff_len = i_grp_len;
        if (i_grp_len == '0) begin
            eff_len = CNT_W'(1);
        end else if (i_grp_len > CNT_W'(MAX_GRP)) begin
            eff_len = CNT_W'(MAX_GRP);
        end
    end

    always_comb begin
        first = (state_q == IDLE);
        if (first) begin
            close = i_valid && ((eff_len == CNT_W'(1)) || i_last);
        end else begin
            close = i_valid && ((cnt_q == len_q - CNT_W'(1)) || i_last);
        end
        abort = !i_valid && (state_q == ACC);
        load  = i_valid && !close;
    end

    // Next delay-line contents: shift in the new beat, then overlay the close/abort write-back.
    // After the shift the newest member sits in slot 0 (close) or slot 1 (abort, bubble in slot 0).
    always_comb begin
        slot_d[0] = '{valid: i_valid, loc_max: i_loc_max, grp_max: i_loc_max,
                      last: 1'b0, partial: 1'b0};
        for (int k = 1; k < MAX_GRP; k++) begin
            slot_d[k] = slot_q[k-1];
        end
        for (int k = 0; k < MAX_GRP; k++) begin
            if (close && (k <= int'(cnt_q))) begin
                slot_d[k].grp_max = front;
                if (k == 0) begin
                    slot_d[k].last = 1'b1;
                end
            end
            if (abort && (k >= 1) && (k <= int'(cnt_q))) begin
                slot_d[k].grp_max = acc;
                slot_d[k].partial = 1'b1;
                if (k == 1) begin
                    slot_d[k].last = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= CNT_W'(1);
            for (int k = 0; k < MAX_GRP; k++) begin
                slot_q[k] <= '{valid: 1'b0, loc_max: '0, grp_max: MIN_VAL,
                               last: 1'b0, partial: 1'b0};
                byp_q[k]  <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < MAX_GRP; k++) begin
                slot_q[k] <= slot_d[k];
            end
            byp_q[0] <= i_byp;
            for (int k = 1; k < MAX_GRP; k++) begin
                byp_q[k] <= byp_q[k-1];
            end

            if (close || abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (load) begin
                if (first) begin
                    state_q <= ACC;
                    len_q   <= eff_len;
                    cnt_q   <= CNT_W'(1);
                end else begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Invalid slots present all-zero fields so the reset image reads 0 on every output.
    assign out_beat  = slot_q[MAX_GRP-1];
    assign o_valid   = out_beat.valid;
    assign o_grp_max = out_beat.valid ? out_beat.grp_max : '0;
    assign o_loc_max = out_beat.valid ? out_beat.loc_max : '0;
    assign o_last    = out_beat.valid && out_beat.last;
    assign o_partial = out_beat.valid && out_beat.partial;
    assign o_byp     = byp_q[MAX_GRP-1];

endmodule

// File: tb/tb_grouped_max_broadcast.sv
// Directed scoreboard bench: expected beats are queued at issue, a negedge monitor pops and compares.
module tb_grouped_max_broadcast;

    localparam int MAX_GRP = 12;
    localparam int BYP_W   = 64;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst, en, valid, last;
    logic [15:0]       loc;
    logic [CNT_W-1:0]  grp_len;
    logic [BYP_W-1:0]  byp;
    logic              o_valid, o_last, o_partial;
    logic [15:0]       o_grp_max, o_loc_max;
    logic [BYP_W-1:0]  o_byp;

    typedef struct {
        logic [15:0]      loc;
        logic [15:0]      gmax;
        logic             last;
        logic             partial;
        logic [BYP_W-1:0] byp;
        int               t_out;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ecyc  = 0;
    int   seq   = 0;
    logic adv   = 1'b0;
    logic stall = 1'b0;
    logic [15:0] p_gmax, p_loc;
    logic        p_valid, p_last, p_partial;

    always #5 clk = ~clk;

    grouped_max_broadcast #(.MAX_GRP(MAX_GRP), .BYP_W(BYP_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_loc_max(loc),
        .i_last(last), .i_grp_len(grp_len), .i_byp(byp),
        .o_valid(o_valid), .o_grp_max(o_grp_max), .o_loc_max(o_loc_max),
        .o_last(o_last), .o_partial(o_partial), .o_byp(o_byp)
    );

    always @(posedge clk) begin
        adv   <= en && !rst;
        stall <= !en && !rst;
        if (en && !rst) ecyc <= ecyc + 1;
    end

    always @(negedge clk) begin
        if (adv && o_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got grp_max=%0d loc=%0d, expected no valid beat",
                         $signed(o_grp_max), $signed(o_loc_max));
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (o_grp_max !== e.gmax || o_loc_max !== e.loc || o_last !== e.last ||
                    o_partial !== e.partial || o_byp !== e.byp || ecyc != e.t_out) begin
                    fails++;
                    $display("FAIL beat: got gmax=%0d loc=%0d last=%0b part=%0b byp=%h t=%0d, expected gmax=%0d loc=%0d last=%0b part=%0b byp=%h t=%0d",
                             $signed(o_grp_max), $signed(o_loc_max), o_last, o_partial, o_byp, ecyc,
                             $signed(e.gmax), $signed(e.loc), e.last, e.partial, e.byp, e.t_out);
                end
            end
        end else if (stall) begin
            tests++;
            if (o_valid !== p_valid || o_grp_max !== p_gmax || o_loc_max !== p_loc ||
                o_last !== p_last || o_partial !== p_partial) begin
                fails++;
                $display("FAIL stall_hold: got valid=%0b gmax=%0d, expected valid=%0b gmax=%0d",
                         o_valid, $signed(o_grp_max), p_valid, $signed(p_gmax));
            end
        end
        p_valid = o_valid; p_gmax = o_grp_max; p_loc = o_loc_max;
        p_last = o_last; p_partial = o_partial;
    end

    task automatic beat(input int lv, input logic lst, input int len, input logic chk,
                        input int eg, input logic el, input logic ep);
        exp_t e;
        en = 1'b1; valid = 1'b1; loc = 16'(lv); last = lst; grp_len = CNT_W'(len);
        byp = {32'hB0B0_0000 | 32'(seq), 32'(seq)};
        seq++;
        if (chk) begin
            e.loc = 16'(lv); e.gmax = 16'(eg); e.last = el; e.partial = ep;
            e.byp = byp; e.t_out = ecyc + MAX_GRP;
            sb.push_back(e);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1; valid = 1'b0; last = 1'b1; loc = 16'($urandom);
            byp = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
        end
    endtask

    // Inputs toggle during the stall to show they are ignored.
    task automatic hold_en(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b0; valid = 1'b1; last = 1'b1; loc = 16'h7FFF; grp_len = 4'd1;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic full_group;
        beat(3,  1'b0, 4, 1'b1, 7, 1'b0, 1'b0);
        beat(-5, 1'b0, 4, 1'b1, 7, 1'b0, 1'b0);
        beat(7,  1'b0, 4, 1'b1, 7, 1'b0, 1'b0);
        beat(1,  1'b0, 4, 1'b1, 7, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; valid = 1'b0; last = 1'b0; loc = '0; grp_len = '0; byp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0 || o_grp_max !== 16'h0 || o_loc_max !== 16'h0 ||
            o_last !== 1'b0 || o_partial !== 1'b0 || o_byp !== '0) begin
            fails++;
            $display("FAIL reset_state: got valid=%0b gmax=%h loc=%h last=%0b part=%0b byp=%h, expected all 0",
                     o_valid, o_grp_max, o_loc_max, o_last, o_partial, o_byp);
        end
        rst = 1'b0;

        full_group();
        bubble(2);

        // singletons
        beat(5,      1'b0, 1, 1'b1, 5,      1'b1, 1'b0);
        beat(-2,     1'b0, 1, 1'b1, -2,     1'b1, 1'b0);
        beat(-32768, 1'b0, 1, 1'b1, -32768, 1'b1, 1'b0);
        bubble(1);

        // early close, then a group whose len input changes mid-group
        beat(2, 1'b0, 4, 1'b1, 9, 1'b0, 1'b0);
        beat(9, 1'b1, 4, 1'b1, 9, 1'b1, 1'b0);
        beat(1, 1'b0, 4, 1'b1, 3, 1'b0, 1'b0);
        beat(3, 1'b0, 1, 1'b1, 3, 1'b0, 1'b0);
        beat(2, 1'b0, 2, 1'b1, 3, 1'b0, 1'b0);
        beat(1, 1'b0, 1, 1'b1, 3, 1'b1, 1'b0);
        bubble(1);

        // bubble abort, then normal operation
        beat(-1, 1'b0, 5, 1'b1, -1, 1'b0, 1'b1);
        beat(-4, 1'b0, 5, 1'b1, -1, 1'b0, 1'b1);
        beat(-2, 1'b0, 5, 1'b1, -1, 1'b1, 1'b1);
        bubble(1);
        beat(6, 1'b0, 2, 1'b1, 8, 1'b0, 1'b0);
        beat(8, 1'b0, 2, 1'b1, 8, 1'b1, 1'b0);
        bubble(1);

        // length clamped to 12; 13th beat forced to a singleton
        for (int i = 1; i <= 12; i++) beat(i, 1'b0, 15, 1'b1, 12, (i == 12), 1'b0);
        beat(13, 1'b1, 15, 1'b1, 13, 1'b1, 1'b0);
        // length 0 behaves as 1
        beat(3, 1'b0, 0, 1'b1, 3, 1'b1, 1'b0);
        beat(4, 1'b0, 0, 1'b1, 4, 1'b1, 1'b0);
        bubble(2);

        // stall inside a group
        beat(3,  1'b0, 4, 1'b1, 7, 1'b0, 1'b0);
        beat(-5, 1'b0, 4, 1'b1, 7, 1'b0, 1'b0);
        hold_en(3);
        beat(7,  1'b0, 4, 1'b1, 7, 1'b0, 1'b0);
        beat(1,  1'b0, 4, 1'b1, 7, 1'b1, 1'b0);
        bubble(MAX_GRP + 2);

        // reset mid-group: discarded beats must never emerge and 100 must not leak
        beat(4,   1'b0, 6, 1'b0, 0, 1'b0, 1'b0);
        beat(100, 1'b0, 6, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b1; valid = 1'b1; loc = 16'd50;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_group: got o_valid=%0b, expected 0", o_valid);
        end
        full_group();
        bubble(MAX_GRP + 4);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d beats still expected, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
